// File: rtl/avr_pp_sequencer_if.sv
// Command/completion bus between the host register file and the AVR
// parallel-programming sequencer.
//   cmd_valid/cmd_ready : command handshake (host -> sequencer)
//   cmd_op/data/bs2     : opcode, load byte (bit0 = BS1 for WRITE/READ), BS2
//   done_valid          : one-cycle completion pulse (sequencer -> host)
//   done_data           : byte captured by the last READ
//   done_timeout        : WRITE RDY timeout flag, qualified by done_valid
interface avr_pp_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_bs2;
    logic       done_valid;
    logic [7:0] done_data;
    logic       done_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_bs2,
        input  cmd_ready, done_valid, done_data, done_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_bs2,
        output cmd_ready, done_valid, done_data, done_timeout
    );
endinterface

// File: rtl/avr_pp_sequencer.sv
// Cycle-accurate sequencer for the AVR high-voltage parallel programming pins.
// Takes one command at a time and plays out SETUP -> STROBE -> HOLD ->
// (WAIT_RDY for WRITE) -> DONE on the ZIF socket pins.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   cmd            : command/completion bus (slave side)
//   busy           : high whenever the sequencer is not idle
//   dut_xa0/xa1, dut_bs1/bs2 : mode pins (held until the next command)
//   dut_xtal, dut_pagel      : active-high strobes
//   dut_oe_n, dut_wr_n       : active-low strobes
//   dut_data_out/dut_data_oe : data byte to the DUT and its drive enable
//   dut_data_in, dut_rdy     : DUT data pins and RDY/BSY pin
module avr_pp_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    avr_pp_sequencer_if.slave       cmd,
    output logic                    busy,
    output logic                    dut_xa0,
    output logic                    dut_xa1,
    output logic                    dut_bs1,
    output logic                    dut_bs2,
    output logic                    dut_xtal,
    output logic                    dut_pagel,
    output logic                    dut_oe_n,
    output logic                    dut_wr_n,
    output logic [7:0]              dut_data_out,
    output logic                    dut_data_oe,
    input  logic [7:0]              dut_data_in,
    input  logic                    dut_rdy
);

    localparam logic [2:0] OpLoadCmd = 3'd0;
    localparam logic [2:0] OpAddrLo  = 3'd1;
    localparam logic [2:0] OpAddrHi  = 3'd2;
    localparam logic [2:0] OpDataLo  = 3'd3;
    localparam logic [2:0] OpDataHi  = 3'd4;
    localparam logic [2:0] OpPagel   = 3'd5;
    localparam logic [2:0] OpWrite   = 3'd6;
    localparam logic [2:0] OpRead    = 3'd7;

    localparam logic [15:0] SettleLast = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] SettleCnt  = 16'(SETTLE_CYCLES);
    localparam logic [15:0] PulseLast  = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StHold, StWaitRdy, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  xa_q, xa_d;
    logic        bs1_q, bs1_d;
    logic        bs2_q, bs2_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  done_data_q, done_data_d;
    logic        timeout_q, timeout_d;
    logic        is_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OpLoadCmd;
            xa_q        <= '0;
            bs1_q       <= 1'b0;
            bs2_q       <= 1'b0;
            data_out_q  <= '0;
            done_data_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            xa_q        <= xa_d;
            bs1_q       <= bs1_d;
            bs2_q       <= bs2_d;
            data_out_q  <= data_out_d;
            done_data_q <= done_data_d;
            timeout_q   <= timeout_d;
        end
    end

    assign is_load = (op_q <= OpDataHi);

    // Next-state and pin-latch logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        op_d        = op_q;
        xa_d        = xa_q;
        bs1_d       = bs1_q;
        bs2_d       = bs2_q;
        data_out_d  = data_out_q;
        done_data_d = done_data_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (cmd.cmd_valid) begin
                    state_d   = StSetup;
                    op_d      = cmd.cmd_op;
                    timeout_d = 1'b0;
                    // Mode pins are latched at accept so they are valid from
                    // the first SETUP cycle and persist past DONE.
                    unique case (cmd.cmd_op)
                        OpLoadCmd: begin xa_d = 2'b10; bs1_d = 1'b0; end
                        OpAddrLo:  begin xa_d = 2'b00; bs1_d = 1'b0; end
                        OpAddrHi:  begin xa_d = 2'b00; bs1_d = 1'b1; end
                        OpDataLo:  begin xa_d = 2'b01; bs1_d = 1'b0; end
                        OpDataHi:  begin xa_d = 2'b01; bs1_d = 1'b1; end
                        OpPagel:   bs1_d = 1'b1;
                        default: begin
                            bs1_d = cmd.cmd_data[0];
                            bs2_d = cmd.cmd_bs2;
                        end
                    endcase
                    if (cmd.cmd_op <= OpDataHi) begin
                        data_out_d = cmd.cmd_data;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == SettleLast) begin
                    state_d = StStrobe;
                    cnt_d   = '0;
                end
            end
            StStrobe: begin
                if (cnt_q == PulseLast) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    if (op_q == OpRead) begin
                        done_data_d = dut_data_in;
                    end
                end
            end
            StHold: begin
                cnt_d   = '0;
                state_d = (op_q == OpWrite) ? StWaitRdy : StDone;
            end
            StWaitRdy: begin
                // RDY is blanked for the first SETTLE_CYCLES cycles; a ready
                // DUT wins over a timeout landing on the same cycle.
                if (cnt_q >= SettleCnt && dut_rdy) begin
                    state_d   = StDone;
                    timeout_d = 1'b0;
                end else if (cnt_q == TimeoutCnt) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin and handshake outputs decoded from the current state.
    always_comb begin
        cmd.cmd_ready    = (state_q == StIdle) && !rst;
        cmd.done_valid   = (state_q == StDone);
        cmd.done_timeout = (state_q == StDone) && timeout_q;
        cmd.done_data    = done_data_q;
        busy             = (state_q != StIdle);
        dut_xa0          = xa_q[0];
        dut_xa1          = xa_q[1];
        dut_bs1          = bs1_q;
        dut_bs2          = bs2_q;
        dut_data_out     = data_out_q;
        dut_xtal         = (state_q == StStrobe) && is_load;
        dut_pagel        = (state_q == StStrobe) && (op_q == OpPagel);
        dut_wr_n         = !((state_q == StStrobe) && (op_q == OpWrite));
        // oe_n only ever drops for READ and data_oe only for loads, so the
        // two can never fight over the bus.
        dut_oe_n         = !(((state_q == StSetup) || (state_q == StStrobe)) &&
                             (op_q == OpRead));
        dut_data_oe      = ((state_q == StSetup) || (state_q == StStrobe) ||
                            (state_q == StHold)) && is_load;
    end

endmodule

// File: tb/tb_avr_pp_sequencer.sv
// Directed bench for avr_pp_sequencer (SETTLE=2, PULSE=4, TIMEOUT=100).
// Cycle 0 is the cycle in which a command is presented and accepted.
module tb_avr_pp_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       busy, xa0, xa1, bs1, bs2, xtal, pagel, oe_n, wr_n, data_oe;
    logic [7:0] data_out, data_in;
    logic       rdy;
    int         total = 0;
    int         passed = 0;

    avr_pp_sequencer_if bus ();

    avr_pp_sequencer #(
        .SETTLE_CYCLES (2),
        .PULSE_CYCLES  (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (bus.slave),
        .busy        (busy),
        .dut_xa0     (xa0),
        .dut_xa1     (xa1),
        .dut_bs1     (bs1),
        .dut_bs2     (bs2),
        .dut_xtal    (xtal),
        .dut_pagel   (pagel),
        .dut_oe_n    (oe_n),
        .dut_wr_n    (wr_n),
        .dut_data_out(data_out),
        .dut_data_oe (data_oe),
        .dut_data_in (data_in),
        .dut_rdy     (rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic b2);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_bs2   = b2;
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0;
        bus.cmd_data = 8'h00;
        bus.cmd_bs2 = 1'b0;
        data_in = 8'h00;
        rdy = 1'b1;

        // Reset values
        tick();
        tick();
        chk("rst_ready", 0, 16'(bus.cmd_ready), 16'd0);
        chk("rst_busy", 0, 16'(busy), 16'd0);
        chk("rst_done_data", 0, 16'(bus.done_data), 16'h00);
        chk("rst_oe_n_wr_n", 0, 16'({oe_n, wr_n}), 16'b11);
        chk("rst_pins", 0, 16'({xa0, xa1, bs1, bs2, xtal, pagel, data_oe}), 16'd0);
        chk("rst_data_out", 0, 16'(data_out), 16'h00);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 0, 16'(bus.cmd_ready), 16'd1);

        // ADDR_HI 0xA5
        issue(3'd2, 8'hA5, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            if (c == 1) begin
                chk("ah_xa_bs1", c, 16'({xa1, xa0, bs1}), 16'b001);
                chk("ah_data_out", c, 16'(data_out), 16'hA5);
            end
            chk("ah_data_oe", c, 16'(data_oe), 16'(c >= 1 && c <= 7));
            chk("ah_xtal", c, 16'(xtal), 16'(c >= 3 && c <= 6));
            chk("ah_done", c, 16'(bus.done_valid), 16'(c == 8));
            chk("ah_ready", c, 16'(bus.cmd_ready), 16'(c == 9));
        end

        // READ bs1=1 bs2=0, data 0x3C on the pins through capture
        issue(3'd7, 8'h01, 1'b0);
        data_in = 8'h3C;
        for (int c = 1; c <= 9; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            if (c == 7) data_in = 8'h55;
            chk("rd_oe_n", c, 16'(oe_n), 16'(!(c >= 1 && c <= 6)));
            chk("rd_data_oe", c, 16'(data_oe), 16'd0);
            chk("rd_done", c, 16'(bus.done_valid), 16'(c == 8));
            chk("rd_done_data", c, 16'(bus.done_data), (c >= 7) ? 16'h3C : 16'h00);
            if (c == 1) chk("rd_bs", c, 16'({bs1, bs2}), 16'b10);
        end

        // WRITE, RDY low from cycle 5, high again at cycle 20
        issue(3'd6, 8'h00, 1'b1);
        rdy = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            rdy = !(c >= 5 && c < 20);
            chk("wr_wr_n", c, 16'(wr_n), 16'(!(c >= 3 && c <= 6)));
            chk("wr_done", c, 16'(bus.done_valid), 16'(c == 21));
            if (c == 21) chk("wr_timeout", c, 16'(bus.done_timeout), 16'd0);
        end

        // WRITE with RDY stuck low -> timeout
        issue(3'd6, 8'h01, 1'b0);
        rdy = 1'b0;
        for (int c = 1; c <= 111; c++) begin
            tick();
            bus.cmd_valid = 1'b0;
            if (c >= 109 && c <= 110) issue(3'd0, 8'h40, 1'b0);
            chk("to_done", c, 16'(bus.done_valid), 16'(c == 109));
            if (c == 109) chk("to_timeout", c, 16'(bus.done_timeout), 16'd1);
            if (c == 110) chk("to_ready", c, 16'(bus.cmd_ready), 16'd1);
            if (c == 111) chk("to_next_busy", c, 16'(busy), 16'd1);
        end
        rdy = 1'b1;
        for (int c = 0; c < 9; c++) tick();

        // LOAD_CMD with cmd_valid held high: accepts at cycles 0, 9, 18
        issue(3'd0, 8'h80, 1'b0);
        for (int c = 1; c <= 27; c++) begin
            tick();
            if (c >= 19) bus.cmd_valid = 1'b0;
            chk("b2b_ready", c, 16'(bus.cmd_ready), 16'(c == 9 || c == 18 || c == 27));
            chk("b2b_xtal", c, 16'(xtal),
                16'((c >= 3 && c <= 6) || (c >= 12 && c <= 15) || (c >= 21 && c <= 24)));
            if (c == 1) chk("b2b_xa", c, 16'({xa1, xa0}), 16'b10);
            if (c == 10) chk("b2b_setup_busy", c, 16'(busy), 16'd1);
        end

        // PAGEL interrupted by reset, then a DATA_LO after release
        issue(3'd5, 8'h00, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c != 6) bus.cmd_valid = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 6) begin
                rst = 1'b0;
                issue(3'd3, 8'h5A, 1'b0);
                #1;
                chk("pg_ready_release", c, 16'(bus.cmd_ready), 16'd1);
            end
            if (c == 5) chk("pg_rst_ready_busy", c, 16'({bus.cmd_ready, busy}), 16'd0);
            chk("pg_pagel", c, 16'(pagel), 16'(c >= 3 && c <= 4));
            chk("pg_done", c, 16'(bus.done_valid), 16'(c == 14));
            if (c == 7) begin
                chk("dl_xa", c, 16'({xa1, xa0}), 16'b01);
                chk("dl_data", c, 16'({data_oe, data_out}), 16'h15A);
            end
            if (c == 14) chk("dl_done_data_kept", c, 16'(bus.done_data), 16'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
